// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave's data-phase state encoding.
// Reused by bus masters, models and other slaves on the same fabric.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAITST = 2'd1;
  localparam logic [1:0] ST_ERR1   = 2'd2;
  localparam logic [1:0] ST_ERR2   = 2'd3;

  // Byte lanes touched by a transfer of the given size at the given low address bits.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << a;
      HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM with per-byte write enables and a combinational read port.
// Contents are never reset.
module ahb_sram_array #(
  parameter int DEPTH = 256,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic [3:0]      we,
  input  logic [IDXW-1:0] addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[addr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = mem[addr];
    end
  endgenerate

endmodule

// File: rtl/ahb_sram_slv.sv
// AHB-Lite SRAM slave: address/data phase pipeline, programmable NONSEQ wait states,
// two-cycle ERROR response for out-of-range, oversize or misaligned accesses.
module ahb_sram_slv
  import ahb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 256,
  parameter int WAIT  = 0
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata
);

  localparam int            IDXW       = $clog2(DEPTH);
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH * 4);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            act_q, act_d;
  logic            write_q, write_d;
  logic [2:0]      size_q, size_d;
  logic [IDXW+1:0] addr_q, addr_d;

  logic        accept;
  logic        misalign;
  logic        illegal;
  logic        wr_commit;
  logic [3:0]  we;
  logic [31:0] mem_rdata;

  // Burst type and protection carry no meaning for a plain SRAM.
  logic unused_ok;
  assign unused_ok = ^{hburst, hprot};

  assign accept = hsel & hready & htrans[1];

  always_comb begin
    misalign = ((hsize == HSIZE_HALF) && haddr[0]) ||
               ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    illegal  = (haddr >= ADDR_LIMIT) || (hsize > HSIZE_WORD) || misalign;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        // Data phase ends here, so this is the only place a new address phase is taken.
        state_d = ST_IDLE;
        act_d   = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else begin
            act_d   = 1'b1;
            write_d = hwrite;
            size_d  = hsize;
            addr_d  = haddr[IDXW+1:0];
            if ((htrans == HTRANS_NONSEQ) && (WAIT > 0)) begin
              state_d = ST_WAITST;
              cnt_d   = 4'(WAIT - 1);
            end
          end
        end
      end
      ST_WAITST: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      act_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
    end
  end

  // A write lands on the edge that closes its data phase; reset drops it.
  assign wr_commit = act_q & write_q & (state_q == ST_IDLE) & hresetn;
  assign we        = wr_commit ? byte_en(size_q, addr_q[1:0]) : 4'b0000;

  ahb_sram_array #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_array (
    .clk   (hclk),
    .we    (we),
    .addr  (addr_q[IDXW+1:2]),
    .wdata (hwdata[31:0]),
    .rdata (mem_rdata)
  );

  assign hreadyout = (state_q != ST_WAITST) && (state_q != ST_ERR1);
  assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = (act_q && !write_q && (state_q == ST_IDLE)) ? DW'(mem_rdata) : '0;

endmodule
